// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the clocks-per-tick helper
// (the helper is also used by the transmitter's baud generator).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int calc_divisor(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick generator: a registered one-clock o_tick every DIVISOR clocks,
// counting from reset.
module uart_rx_tick_gen #(
  parameter int DIVISOR = 27
) (
  input  logic clk,
  input  logic resetn,
  output logic o_tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 2-FF line synchroniser, oversampled frame FSM and a valid/ack holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra parity_err pulse output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIVISOR    = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       RxD,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);
  localparam logic [SC_W-1:0] SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  logic                 r_rx_meta;
  logic                 r_rxs;
  logic                 w_tick;
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [SC_W-1:0]      r_sc;
  logic [BI_W-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_dout;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_mid;
  logic                 w_end;
  logic                 w_sc_clr;
  logic                 w_sc_inc;
  logic                 w_bit_clr;
  logic                 w_shift_en;
  logic                 w_stop_done;
  logic                 w_load;
  logic                 w_overrun;
  logic                 w_frame_err;
  logic                 w_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_parity_err;
  logic                 w_par_en;
  logic                 w_par_fail;
`endif

  // RxD is asynchronous; everything downstream sees only r_rxs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rxs     <= r_rx_meta;
    end
  end

  uart_rx_tick_gen #(
    .DIVISOR (DIVISOR)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .o_tick (w_tick)
  );

  assign w_mid = w_tick && (r_sc == SC_MID);
  assign w_end = w_tick && (r_sc == SC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!r_rxs) w_state_next = START;
      START:   if (w_mid) w_state_next = r_rxs ? IDLE : DATA;
      DATA:    if (w_end && (r_bit_idx == BIT_LAST)) w_state_next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:  if (w_end) w_state_next = STOP;
`endif
      STOP:    if (w_end) w_state_next = r_rxs ? IDLE : BREAK;
      // A line held low after a bad stop bit must go high before a new start can count.
      BREAK:   if (r_rxs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_sc_clr    = 1'b0;
    w_sc_inc    = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_done = 1'b0;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    w_frame_err = 1'b0;
    w_busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    w_par_en    = 1'b0;
`endif
    case (r_state)
      IDLE: w_sc_clr = 1'b1;
      START: begin
        if (w_mid) begin
          w_sc_clr  = 1'b1;
          w_bit_clr = 1'b1;
        end else begin
          w_sc_inc = w_tick;
        end
      end
      DATA: begin
        if (w_end) begin
          w_sc_clr   = 1'b1;
          w_shift_en = 1'b1;
        end else begin
          w_sc_inc = w_tick;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_end) begin
          w_sc_clr = 1'b1;
          w_par_en = 1'b1;
        end else begin
          w_sc_inc = w_tick;
        end
      end
`endif
      STOP: begin
        if (w_end) begin
          w_sc_clr    = 1'b1;
          w_stop_done = 1'b1;
          // An ack arriving with the new byte frees the slot, so the load wins over overrun.
          if (r_rxs) begin
            w_load    = !r_rx_valid || rx_ack;
            w_overrun = r_rx_valid && !rx_ack;
          end else begin
            w_frame_err = 1'b1;
          end
        end else begin
          w_sc_inc = w_tick;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sc      <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_sc_clr) begin
        r_sc <= '0;
      end else if (w_sc_inc) begin
        r_sc <= r_sc + SC_W'(1);
      end
      if (w_bit_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + BI_W'(1);
      end
      if (w_shift_en) begin
        r_shift[r_bit_idx] <= r_rxs;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout      <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
      if (w_load) begin
        r_dout     <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_fail = (^r_shift) ^ r_par_bit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_par_en) begin
        r_par_bit <= r_rxs;
      end
      r_parity_err <= w_stop_done && w_par_fail;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign dout      = r_dout;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = w_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level scoreboard of delivered bytes and error pulses, compared every
// cycle, plus directed literal checks. Honours UART_RX_PARITY_EN.
module tb_uart_receiver;

  localparam int CLK_FREQ = 3200000;
  localparam int BAUD     = 100000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT_CLKS = OS * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 10;
`else
  localparam int STOP_OFS = 9;
`endif

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       RxD    = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] dout;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .RxD        (RxD),
    .dout       (dout),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    bit         stop_ok;
    logic [7:0] data;
    bit         par_bad;
  } ev_t;

  ev_t        evq[$];
  int         cyc      = 0;
  int         r0       = 0;
  int         ack_at   = -1;
  bit         rand_ack = 1'b0;
  int         n_cmp    = 0;
  int         n_err    = 0;
  logic [7:0] m_dout   = 8'h00;
  bit         m_valid  = 1'b0;
  bit         m_fe     = 1'b0;
  bit         m_ov     = 1'b0;
  bit         m_pe     = 1'b0;
  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         pe_cnt   = 0;
  int         rise_cyc = 0;
  bit         prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: at each edge apply the frame outcome due at that edge and the ack handshake,
  // then compare every output at the following falling edge.
  always @(posedge clk) begin
    ev_t ev;
    bit  ack_s;
    bit  load;
    ack_s = rx_ack;
    load  = 1'b0;
    cyc++;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
    if (resetn) begin
      if (evq.size() > 0 && evq[0].edge_n == cyc) begin
        ev   = evq.pop_front();
        m_pe = ev.par_bad;
        if (!ev.stop_ok) begin
          m_fe = 1'b1;
          $display("cycle %0d: frame error on byte 0x%02h", cyc, ev.data);
        end else if (!m_valid || ack_s) begin
          load = 1'b1;
          m_dout = ev.data;
          $display("cycle %0d: byte 0x%02h delivered", cyc, ev.data);
        end else begin
          m_ov = 1'b1;
          $display("cycle %0d: overrun, byte 0x%02h dropped", cyc, ev.data);
        end
      end
      if (load) m_valid = 1'b1;
      else if (m_valid && ack_s) m_valid = 1'b0;
    end
    @(negedge clk);
    if (!resetn) begin
      m_valid = 1'b0;
      m_dout  = 8'h00;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      m_pe    = 1'b0;
      evq.delete();
    end
    check("rx_valid", rx_valid, m_valid);
    check("dout", dout, m_dout);
    check("frame_err", frame_err, m_fe);
    check("overrun", overrun, m_ov);
`ifdef UART_RX_PARITY_EN
    check("parity_err", parity_err, m_pe);
`endif
  end

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  always @(posedge clk) begin
    #2;
    rx_ack = (cyc + 1 == ack_at) || (rand_ack && ($urandom_range(0, 9) == 0));
  end

  // Edge at which the stop bit is judged for a frame whose start bit began after edge k:
  // 3 edges of synchroniser/start detection, then the first free-running tick, then
  // half a bit to mid-start and one bit per following field.
  function automatic int stop_edge(input int k);
    int t1;
    t1 = k + 4;
    while (((t1 - r0) % DIV) != 0) t1++;
    return t1 + (OS / 2 - 1) * DIV + STOP_OFS * BIT_CLKS;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    RxD = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] data, input bit stop_ok, input bit bad_par,
                           input bit ack_on_stop, output int k);
    ev_t ev;
    @(posedge clk);
    #1;
    k          = cyc;
    ev.edge_n  = stop_edge(k);
    ev.stop_ok = stop_ok;
    ev.data    = data;
    ev.par_bad = bad_par;
    evq.push_back(ev);
    if (ack_on_stop) ack_at = ev.edge_n;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ bad_par, BIT_CLKS);
`endif
  endtask

  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit ack_on_stop,
                            output int k);
    send_head(data, 1'b1, bad_par, ack_on_stop, k);
    drive_bit(1'b1, BIT_CLKS);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1;
    ack_at = cyc + 1;
    @(posedge clk);
    #1;
    check("ack_clears_next_clk", rx_valid, 1'b0);
  endtask

  initial begin
    int k;
    int d;
    int fe0;
    int ov0;
    int pe0;
    logic [7:0] rd;
    bit fe;
    bit bp;

    #1 resetn = 1'b0;
    #2;
    check("reset_dout", dout, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    r0 = cyc + 1;
    repeat (5) @(posedge clk);

    // 0xA5, no ack, then a single ack
    send_frame(8'hA5, 1'b0, 1'b0, k);
    check("a5_dout", dout, 8'hA5);
    check("a5_valid", rx_valid, 1'b1);
    d = rise_cyc - (k + STOP_OFS * BIT_CLKS);
    check("a5_latency_window", (d >= 17 && d <= 20), 1'b1);
    pulse_ack();

    // 10-clock low glitch is a false start
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    @(posedge clk);
    #1;
    drive_bit(1'b0, 10);
    check("glitch_busy", busy, 1'b1);
    drive_bit(1'b1, 40);
    check("glitch_idle", busy, 1'b0);
    check("glitch_no_valid", rx_valid, 1'b0);
    check("glitch_no_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 0x3C with stop bit held low for 64 clocks
    fe0 = fe_cnt;
    send_head(8'h3C, 1'b0, 1'b0, 1'b0, k);
    drive_bit(1'b0, 50);
    check("break_busy", busy, 1'b1);
    check("break_fe_pulses", fe_cnt - fe0, 1);
    check("break_no_valid", rx_valid, 1'b0);
    drive_bit(1'b0, 14);
    drive_bit(1'b1, 10);
    check("break_exit", busy, 1'b0);
    drive_bit(1'b1, 22);

    // 0x11 then 0x22 back to back, no ack
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b0, 1'b0, k);
    send_frame(8'h22, 1'b0, 1'b0, k);
    check("ovr_dout", dout, 8'h11);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_pulses", ov_cnt - ov0, 1);
    pulse_ack();

    // 0x55 left pending, ack coincides with the 0x66 load
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b0, 1'b0, k);
    send_frame(8'h66, 1'b0, 1'b1, k);
    check("coll_dout", dout, 8'h66);
    check("coll_valid", rx_valid, 1'b1);
    check("coll_no_overrun", ov_cnt - ov0, 0);

    // Reset in the middle of the data bits of 0xF0
    @(posedge clk);
    #1;
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b0, 3 * BIT_CLKS + BIT_CLKS / 2);
    check("abort_busy", busy, 1'b1);
    resetn = 1'b0;
    RxD    = 1'b1;
    #1;
    check("abort_dout", dout, 8'h00);
    check("abort_valid", rx_valid, 1'b0);
    check("abort_busy_cleared", busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b1;
    r0 = cyc + 1;
    repeat (3) @(posedge clk);
    send_frame(8'h0F, 1'b0, 1'b0, k);
    check("after_reset_dout", dout, 8'h0F);
    check("after_reset_valid", rx_valid, 1'b1);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b0, k);
    check("par_pulses", pe_cnt - pe0, 1);
    check("par_dout", dout, 8'h07);
    check("par_valid", rx_valid, 1'b1);
    pulse_ack();
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", pe_cnt - pe0, 0);
`endif

    // Random bytes, gaps, framing errors and ack timing
    rand_ack = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom());
      fe = ($urandom_range(0, 7) == 0);
      bp = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      if (fe) begin
        send_head(rd, 1'b0, bp, 1'b0, k);
        drive_bit(1'b0, 40);
        drive_bit(1'b1, BIT_CLKS);
      end else begin
        send_frame(rd, bp, 1'b0, k);
      end
    end
    rand_ack = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("events_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
